// File: rtl/secded_dec_pipe_pkg.sv
// Shared types and codeword-layout helpers for the extended-Hamming SEC/DED blocks.
package secded_pkg;

  typedef enum logic [1:0] {CLEAN, SB, DB} err_kind_e;

  // Smallest P with 2^P >= data_w + P + 1.
  function automatic int unsigned calc_p(input int unsigned data_w);
    int unsigned p = 1;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << p) < data_w + p + 1) p = p + 1;
    end
    return p;
  endfunction

  // Codeword position (1-based) of data bit idx: the idx-th non-power-of-two position.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt = 0;
    int unsigned pos = 0;
    for (int unsigned p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt = cnt + 1;
      end
    end
    return pos;
  endfunction

  // Inverse of data_pos for non-power-of-two positions.
  function automatic int unsigned pos_data(input int unsigned pos);
    int unsigned n = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      if ((32'd1 << k) <= pos) n = n + 1;
    end
    return pos - n - 1;
  endfunction

endpackage

// File: rtl/secded_dec_pipe_if.sv
// Valid/ready stream bundle between a read port, the SEC/DED decoder and its consumer.
interface secded_dec_pipe_if
  import secded_pkg::*;
#(
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned P     = calc_p(DATA_W);
  localparam int unsigned CHK_W = P + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              corr_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [P-1:0]      out_syn;
  logic              out_sb;
  logic              out_db;

  modport master (
    output in_valid, in_data, in_chk, corr_en, out_ready,
    input  in_ready, out_valid, out_data, out_syn, out_sb, out_db
  );

  modport slave (
    input  in_valid, in_data, in_chk, corr_en, out_ready,
    output in_ready, out_valid, out_data, out_syn, out_sb, out_db
  );
endinterface

// File: rtl/secded_dec_pipe_syndrome.sv
// Combinational syndrome / overall-parity generator, shared by decoder and encoder.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter  int unsigned DATA_W = 16,
  localparam int unsigned P      = calc_p(DATA_W),
  localparam int unsigned CHK_W  = P + 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic [CHK_W-1:0]  chk,
  output logic [P-1:0]      syn,
  output logic              par
);

  logic [P-1:0] term [DATA_W];

  // Each set data bit contributes its codeword index; check bits sit at 2^k, so they fold in as a vector.
  for (genvar i = 0; i < DATA_W; i++) begin : g_term
    assign term[i] = data[i] ? P'(data_pos(i)) : '0;
  end

  always_comb begin
    syn = chk[P-1:0];
    for (int unsigned i = 0; i < DATA_W; i++) begin
      syn = syn ^ term[i];
    end
    par = ^{data, chk};
  end

endmodule

// File: rtl/secded_dec_pipe.sv
// Two-stage pipelined SEC/DED decoder with detect-only mode and saturating error counters.
module secded_dec_pipe
  import secded_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  secded_dec_pipe_if.slave  bus,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  sb_cnt,
  output logic [CNT_W-1:0]  db_cnt
);

  localparam int unsigned P       = calc_p(DATA_W);
  localparam int unsigned POS_MAX = DATA_W + P;

  logic              advance;
  logic              hs;
  logic [P-1:0]      syn_c;
  logic              par_c;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [P-1:0]      s1_syn;
  logic              s1_par;
  logic              s1_corr;

  err_kind_e         kind;
  logic [DATA_W-1:0] hit;
  logic [DATA_W-1:0] fixed;

  assign advance     = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;
  assign hs          = bus.out_valid & bus.out_ready;

  secded_syndrome #(.DATA_W(DATA_W)) u_syn (
    .data (bus.in_data),
    .chk  (bus.in_chk),
    .syn  (syn_c),
    .par  (par_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
      s1_corr  <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      s1_data  <= bus.in_data;
      s1_syn   <= syn_c;
      s1_par   <= par_c;
      s1_corr  <= bus.corr_en;
    end
  end

  // One-hot flip mask: power-of-two, zero and out-of-range syndromes match no data bit.
  for (genvar i = 0; i < DATA_W; i++) begin : g_hit
    assign hit[i] = (s1_syn == P'(data_pos(i)));
  end

  always_comb begin
    kind = CLEAN;
    if (s1_par) begin
      kind = (32'(s1_syn) > POS_MAX) ? DB : SB;
    end else if (s1_syn != '0) begin
      kind = DB;
    end
    fixed = s1_data;
    if (kind == SB && s1_corr) fixed = s1_data ^ hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_syn   <= '0;
      bus.out_sb    <= 1'b0;
      bus.out_db    <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data <= fixed;
        bus.out_syn  <= s1_syn;
        bus.out_sb   <= (kind == SB);
        bus.out_db   <= (kind == DB);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      sb_cnt <= '0;
      db_cnt <= '0;
    end else begin
      if (hs && bus.out_sb && sb_cnt != '1) sb_cnt <= sb_cnt + CNT_W'(1);
      if (hs && bus.out_db && db_cnt != '1) db_cnt <= db_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_secded_dec_pipe.sv
// Scoreboard bench for secded_dec_pipe: randomized words against a codeword-array reference model.
module tb_secded_dec_pipe;

  localparam int DW   = 16;
  localparam int NPOS = 21;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [7:0] sb_cnt, db_cnt;

  always #5 clk = ~clk;

  secded_dec_pipe_if #(.DATA_W(DW)) bus ();

  secded_dec_pipe #(.DATA_W(DW), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .sb_cnt  (sb_cnt),
    .db_cnt  (db_cnt)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  syn;
    logic        sb;
    logic        db;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   m_sb = 0;
  int   m_db = 0;
  bit   rand_rdy = 0;

  function automatic bit is_pow2(int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic int pos_of(int idx);
    int cnt = 0;
    int res = 0;
    for (int p = 1; p <= NPOS; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  function automatic logic [5:0] encode(logic [15:0] d);
    bit cw [1:NPOS];
    logic [5:0] c = '0;
    for (int p = 1; p <= NPOS; p++) cw[p] = 1'b0;
    for (int i = 0; i < DW; i++) cw[pos_of(i)] = d[i];
    for (int k = 0; k < 5; k++)
      for (int p = 1; p <= NPOS; p++)
        if (((p >> k) & 1) == 1) c[k] = c[k] ^ cw[p];
    c[5] = (^d) ^ (^c[4:0]);
    return c;
  endfunction

  function automatic exp_t model(logic [15:0] d, logic [5:0] c, bit corr);
    bit   cw [1:NPOS];
    int   syn = 0;
    bit   par;
    exp_t e;
    for (int p = 1; p <= NPOS; p++) cw[p] = 1'b0;
    for (int i = 0; i < DW; i++) cw[pos_of(i)] = d[i];
    for (int k = 0; k < 5; k++) cw[1 << k] = c[k];
    for (int p = 1; p <= NPOS; p++) if (cw[p]) syn = syn ^ p;
    par   = (^d) ^ (^c);
    e.d   = d;
    e.syn = syn[4:0];
    e.sb  = 1'b0;
    e.db  = 1'b0;
    if (par) begin
      if (syn > NPOS) e.db = 1'b1;
      else begin
        e.sb = 1'b1;
        if (corr)
          for (int i = 0; i < DW; i++) if (pos_of(i) == syn) e.d[i] = ~e.d[i];
      end
    end else if (syn != 0) begin
      e.db = 1'b1;
    end
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(logic [15:0] d, logic [5:0] c, bit corr);
    bit done = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_chk   = c;
    bus.corr_en  = corr;
    for (int n = 0; n < 1000 && !done; n++) begin
      #1;
      if (bus.in_ready) begin
        q.push_back(model(d, c, corr));
        done = 1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready never rose for word %0h", d);
    end
  endtask

  task automatic send_err(logic [15:0] d, int nflip, bit corr);
    logic [21:0] w;
    logic [21:0] mask = '0;
    int b;
    w = {encode(d), d};
    for (int f = 0; f < nflip; f++) begin
      do b = $urandom_range(0, 21); while (mask[b]);
      mask[b] = 1'b1;
    end
    w = w ^ mask;
    send(w[15:0], w[21:16], corr);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty = 0;
    for (int n = 0; n < 1000 && !empty; n++) begin
      @(negedge clk);
      #3;
      if (q.size() == 0 && !bus.out_valid) empty = 1;
    end
    if (!empty) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d words still pending", q.size());
    end
  endtask

  // Monitor / scoreboard: decisions taken mid-low-phase, for the coming rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      check("sb_cnt", sb_cnt, m_sb);
      check("db_cnt", db_cnt, m_db);
      check("in_ready", bus.in_ready, (!bus.out_valid || bus.out_ready));
      if (!rst_n) begin
        q.delete();
        m_sb = 0;
        m_db = 0;
      end else begin
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: data %0h with nothing pending", bus.out_data);
          end else begin
            e = q[0];
            check("out_data", bus.out_data, e.d);
            check("out_syn", bus.out_syn, e.syn);
            check("out_sb", bus.out_sb, e.sb);
            check("out_db", bus.out_db, e.db);
            if (bus.out_ready) begin
              void'(q.pop_front());
              if (e.sb && m_sb < 255) m_sb++;
              if (e.db && m_db < 255) m_db++;
            end
          end
        end
        if (clr_cnt) begin
          m_sb = 0;
          m_db = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    logic [5:0] c;
    bit seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_chk    = '0;
    bus.corr_en   = 1'b1;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    #3;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_syn", bus.out_syn, 0);
    check("rst_out_sb", bus.out_sb, 0);
    check("rst_out_db", bus.out_db, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_sb_cnt", sb_cnt, 0);
    check("rst_db_cnt", db_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean word and two-cycle latency.
    c = encode(16'hA5A5);
    send(16'hA5A5, c, 1'b1);
    idle();
    #3;
    check("lat_stage1", bus.out_valid, 0);
    @(negedge clk);
    #3;
    check("lat_stage2", bus.out_valid, 1);
    drain();

    // Directed error cases.
    send(16'hA5A5 ^ 16'h0008, c, 1'b1);
    send(16'hA5A5 ^ 16'h0008, c, 1'b0);
    send(16'hA5A5, c ^ 6'h20, 1'b1);
    send(16'hA5A5 ^ 16'h0201, c, 1'b1);
    idle();
    drain();
    check("dir_sb_cnt", sb_cnt, 3);
    check("dir_db_cnt", db_cnt, 1);

    // Backpressure: first output stalls for three cycles.
    seen = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_err(16'($urandom), i % 2, 1'b1);
        idle();
      end
      begin
        for (int n = 0; n < 100 && !seen; n++) begin
          @(negedge clk);
          if (bus.out_valid) seen = 1;
        end
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    check("bp_seen_output", seen, 1);
    drain();

    // Randomized traffic with random consumer throttling.
    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      send_err(16'($urandom), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    idle();
    rand_rdy = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();

    // Saturation.
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    #3;
    check("clr_idle_sb", sb_cnt, 0);
    for (int i = 0; i < 300; i++) send_err(16'($urandom), 1, 1'($urandom));
    idle();
    drain();
    check("sat_sb_cnt", sb_cnt, 255);

    // Clear wins over a same-cycle SB handshake.
    send_err(16'($urandom), 1, 1'b1);
    idle();
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("clr_seen_output", seen, 1);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    #3;
    check("clr_sb_cnt", sb_cnt, 0);
    drain();

    // Reset with two words in flight.
    send_err(16'($urandom), 0, 1'b1);
    send_err(16'($urandom), 1, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    check("rst_flush_valid", bus.out_valid, 0);
    repeat (6) @(negedge clk);
    #3;
    check("rst_flush_later", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
